dvp_pattern_tx: RTL and testbench

Camera-side DVP transmitter that emulates the OV7670-style byte stream (pclk/href/vsync/8-bit data, RGB565, high byte first) consumed by the camera capture path. It generates built-in test patterns, so the capture → SDRAM → VGA chain can be brought up and regressed without a sensor attached. On the board it drives the cmos_* capture inputs through a SW-selected mux. In simulation it drives them directly.

---
 rtl/dvp_pattern_tx.sv | 148 ++++++++++++++
 tb/tb_dvp_pattern_tx.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP transmitter: pclk/href/vsync/8-bit RGB565 byte stream, high byte first,
// carrying built-in test patterns so the capture path can be exercised without a sensor.
module dvp_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       dvp_pclk,
    output logic       dvp_vsync,
    output logic       dvp_href,
    output logic [7:0] dvp_db,
    output logic       busy,
    output logic       frame_done
);
    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW       = $clog2(LINE_LEN);
    localparam int VW       = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_HREF = HW'(2 * H_ACTIVE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic          pclk_q;
    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [1:0]    pat_q, pat_d;
    logic          done_q, done_d;

    function automatic logic [VW-1:0] last_line(input logic [2:0] s);
        case (s)
            S_VSYNC:  last_line = VW'(VSYNC_LINES - 1);
            S_VBACK:  last_line = VW'(V_BACK - 1);
            S_ACTIVE: last_line = VW'(V_ACTIVE - 1);
            S_VFRONT: last_line = VW'(V_FRONT - 1);
            default:  last_line = '0;
        endcase
    endfunction

    // Everything except pclk advances only on the clk edge where pclk falls.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        fcnt_d  = fcnt_q;
        pat_d   = pat_q;
        done_d  = 1'b0;
        if (pclk_q) begin
            if (state_q == S_IDLE) begin
                if (enable) begin
                    state_d = S_VSYNC;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                    pat_d   = pattern_sel;
                end
            end else if (hcnt_q != H_LAST) begin
                hcnt_d = hcnt_q + 1'b1;
            end else begin
                hcnt_d = '0;
                vcnt_d = vcnt_q + 1'b1;
                if (vcnt_q == last_line(state_q)) begin
                    vcnt_d = '0;
                    case (state_q)
                        S_VSYNC:  state_d = S_VBACK;
                        S_VBACK:  state_d = S_ACTIVE;
                        S_ACTIVE: state_d = S_VFRONT;
                        default: begin
                            done_d  = 1'b1;
                            fcnt_d  = fcnt_q + 1'b1;
                            state_d = enable ? S_VSYNC : S_IDLE;
                            pat_d   = enable ? pattern_sel : pat_q;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_q  <= 1'b0;
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            fcnt_q  <= '0;
            pat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            pclk_q  <= ~pclk_q;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            fcnt_q  <= fcnt_d;
            pat_q   <= pat_d;
            done_q  <= done_d;
        end
    end

    logic [15:0] x, y, pixel;
    logic [2:0]  bar;
    logic [7:0]  grey;

    always_comb begin
        x     = 16'(hcnt_q >> 1);
        y     = 16'(vcnt_q);
        bar   = 3'((32'(x) * 8) / H_ACTIVE);
        grey  = x[7:0];
        pixel = '0;
        case (pat_q)
            2'd0: begin
                case (bar)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = {grey[7:3], grey[7:2], grey[7:3]};
            2'd2:    pixel = {fcnt_q[4:0], 6'h00, ~fcnt_q[4:0]};
            default: pixel = (((x ^ y) & 16'h0008) != '0) ? 16'hFFFF : 16'h0000;
        endcase
    end

    assign dvp_pclk   = pclk_q;
    assign dvp_vsync  = (state_q == S_VSYNC);
    assign dvp_href   = (state_q == S_ACTIVE) && (hcnt_q < H_HREF);
    assign dvp_db     = dvp_href ? (hcnt_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx: each pclk period is compared against a frame-level model
// derived from line/frame geometry and the RGB565 pattern definitions.
module tb_dvp_pattern_tx;
    localparam int HA = 8, HB = 4, VA = 4, VS = 1, VB = 1, VF = 1;
    localparam int LINE  = 2 * HA + HB;
    localparam int FRAME = LINE * (VS + VB + VA + VF);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       dvp_pclk, dvp_vsync, dvp_href, busy, frame_done;
    logic [7:0] dvp_db;

    int n_checks = 0;
    int n_fail   = 0;
    int fc_model = 0;

    dvp_pattern_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .dvp_pclk(dvp_pclk), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
        .dvp_db(dvp_db), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected {vsync, href, db} for pclk period k of a frame.
    function automatic logic [9:0] exp_vhd(input int k, input int pat, input int fc);
        int line, h, x, y, pix, g, f;
        logic vs, hr;
        logic [7:0] db;
        line = k / LINE;
        h    = k % LINE;
        x    = h / 2;
        y    = line - (VS + VB);
        vs   = (line < VS);
        hr   = (line >= VS + VB) && (line < VS + VB + VA) && (h < 2 * HA);
        case (pat)
            0: begin
                case ((x * 8) / HA)
                    0: pix = 'hFFFF;
                    1: pix = 'hFFE0;
                    2: pix = 'h07FF;
                    3: pix = 'h07E0;
                    4: pix = 'hF81F;
                    5: pix = 'hF800;
                    6: pix = 'h001F;
                    default: pix = 0;
                endcase
            end
            1: begin
                g   = x % 256;
                pix = ((g >> 3) << 11) | ((g >> 2) << 5) | (g >> 3);
            end
            2: begin
                f   = fc % 32;
                pix = (f << 11) | (31 - f);
            end
            default: pix = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 'hFFFF : 0;
        endcase
        if (!hr)           db = 8'h00;
        else if (h % 2 == 0) db = 8'((pix >> 8) & 255);
        else               db = 8'(pix & 255);
        return {vs, hr, db};
    endfunction

    task automatic sync_b();
        repeat (4) begin
            @(negedge clk);
            if (dvp_pclk === 1'b1) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fc_model = 0;
        sync_b();
    endtask

    task automatic wait_vsync(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dvp_vsync === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dvp_pclk, dvp_vsync, dvp_href, dvp_db, busy, frame_done} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_state got pclk=%b vs=%b hr=%b db=%h busy=%b done=%b expected all 0",
                     dvp_pclk, dvp_vsync, dvp_href, dvp_db, busy, frame_done);
        end
        rst = 1'b0;
        fc_model = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (dvp_pclk !== 1'(i % 2 == 0) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL pclk_toggle i=%0d got pclk=%b busy=%b expected pclk=%b busy=0",
                         i, dvp_pclk, busy, i % 2 == 0);
            end
        end
        sync_b();
    endtask

    task automatic test_bars();
        logic [9:0] e, g;
        logic [7:0] bytes[$];
        logic [7:0] ref_line[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                     8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        bit ok;
        pattern_sel = 2'd0;
        enable = 1'b1;
        wait_vsync(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bars_start got no vsync expected vsync within 20 pclk"); end
        for (int k = 0; k < FRAME; k++) begin
            if (k == 0) enable = 1'b0;
            e = exp_vhd(k, 0, fc_model);
            g = {dvp_vsync, dvp_href, dvp_db};
            if (dvp_href === 1'b1) bytes.push_back(dvp_db);
            n_checks++;
            if (g !== e || busy !== 1'b1 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL bars k=%0d got vs/hr/db=%b/%b/%h busy=%b done=%b expected %b/%b/%h busy=1 done=0",
                         k, g[9], g[8], g[7:0], busy, frame_done, e[9], e[8], e[7:0]);
            end
            @(negedge clk);
            n_checks++;
            if (frame_done !== 1'(k == FRAME - 1)) begin
                n_fail++;
                $display("FAIL bars_done k=%0d got %b expected %b", k, frame_done, k == FRAME - 1);
            end
            @(negedge clk);
        end
        fc_model++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= bytes.size() || bytes[i] !== ref_line[i]) begin
                n_fail++;
                $display("FAIL bars_line0 byte=%0d got %h expected %h", i,
                         (i < bytes.size()) ? bytes[i] : 8'hxx, ref_line[i]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || dvp_vsync !== 1'b0 || dvp_href !== 1'b0) begin
            n_fail++;
            $display("FAIL bars_idle got busy=%b vs=%b hr=%b expected 0/0/0", busy, dvp_vsync, dvp_href);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e, g;
        logic [15:0] pix;
        logic [15:0] ref_pix[3] = '{16'h001F, 16'h081E, 16'h101D};
        bit ok;
        do_reset();
        pattern_sel = 2'd2;
        enable = 1'b1;
        wait_vsync(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_start got no vsync expected vsync within 20 pclk"); end
        for (int f = 0; f < 3; f++) begin
            pix = 16'h0;
            for (int k = 0; k < FRAME; k++) begin
                if (f == 2 && k == 5) enable = 1'b0;
                if (k == (VS + VB) * LINE)     pix[15:8] = dvp_db;
                if (k == (VS + VB) * LINE + 1) pix[7:0]  = dvp_db;
                e = exp_vhd(k, 2, fc_model);
                g = {dvp_vsync, dvp_href, dvp_db};
                n_checks++;
                if (g !== e || busy !== 1'b1 || frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b f=%0d k=%0d got vs/hr/db=%b/%b/%h busy=%b done=%b expected %b/%b/%h busy=1 done=0",
                             f, k, g[9], g[8], g[7:0], busy, frame_done, e[9], e[8], e[7:0]);
                end
                @(negedge clk);
                n_checks++;
                if (frame_done !== 1'(k == FRAME - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_done f=%0d k=%0d got %b expected %b", f, k, frame_done, k == FRAME - 1);
                end
                @(negedge clk);
            end
            fc_model++;
            n_checks++;
            if (pix !== ref_pix[f]) begin
                n_fail++;
                $display("FAIL b2b_pixel f=%0d got %h expected %h", f, pix, ref_pix[f]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || dvp_vsync !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got busy=%b vs=%b expected 0/0", busy, dvp_vsync);
        end
    endtask

    task automatic test_enable_drop();
        logic [9:0] e, g;
        bit ok;
        pattern_sel = 2'd1;
        enable = 1'b1;
        wait_vsync(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drop_start got no vsync expected vsync within 20 pclk"); end
        for (int k = 0; k < FRAME; k++) begin
            if (k == (VS + VB + 1) * LINE + 3) enable = 1'b0;
            e = exp_vhd(k, 1, fc_model);
            g = {dvp_vsync, dvp_href, dvp_db};
            n_checks++;
            if (g !== e || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL drop k=%0d got vs/hr/db=%b/%b/%h busy=%b expected %b/%b/%h busy=1",
                         k, g[9], g[8], g[7:0], busy, e[9], e[8], e[7:0]);
            end
            @(negedge clk);
            n_checks++;
            if (frame_done !== 1'(k == FRAME - 1)) begin
                n_fail++;
                $display("FAIL drop_done k=%0d got %b expected %b", k, frame_done, k == FRAME - 1);
            end
            @(negedge clk);
        end
        fc_model++;
        for (int i = 0; i < 30; i++) begin
            n_checks++;
            if ({busy, dvp_vsync, dvp_href, dvp_db} !== 11'b0) begin
                n_fail++;
                $display("FAIL drop_idle i=%0d got busy=%b vs=%b hr=%b db=%h expected all 0",
                         i, busy, dvp_vsync, dvp_href, dvp_db);
            end
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_pattern_change();
        logic [9:0] e, g;
        bit ok;
        pattern_sel = 2'd0;
        enable = 1'b1;
        wait_vsync(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL patchg_start got no vsync expected vsync within 20 pclk"); end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FRAME; k++) begin
                if (f == 0 && k == (VS + VB) * LINE + 5) pattern_sel = 2'd3;
                if (f == 1 && k == 3) enable = 1'b0;
                e = exp_vhd(k, (f == 0) ? 0 : 3, fc_model);
                g = {dvp_vsync, dvp_href, dvp_db};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL patchg f=%0d k=%0d got vs/hr/db=%b/%b/%h expected %b/%b/%h",
                             f, k, g[9], g[8], g[7:0], e[9], e[8], e[7:0]);
                end
                @(negedge clk);
                @(negedge clk);
            end
            fc_model++;
        end
    endtask

    task automatic test_random();
        logic [9:0] e, g;
        int cur_pat, next_pat, chg;
        bit ok;
        pattern_sel = 2'($urandom_range(0, 3));
        next_pat = int'(pattern_sel);
        enable = 1'b1;
        wait_vsync(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rand_start got no vsync expected vsync within 20 pclk"); end
        for (int f = 0; f < 4; f++) begin
            cur_pat = next_pat;
            chg = int'($urandom_range(1, FRAME - 2));
            for (int k = 0; k < FRAME; k++) begin
                if (k == chg) begin
                    pattern_sel = 2'($urandom_range(0, 3));
                    next_pat = int'(pattern_sel);
                    if (f == 3) enable = 1'b0;
                end
                e = exp_vhd(k, cur_pat, fc_model);
                g = {dvp_vsync, dvp_href, dvp_db};
                n_checks++;
                if (g !== e || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand f=%0d pat=%0d k=%0d got vs/hr/db=%b/%b/%h busy=%b expected %b/%b/%h busy=1",
                             f, cur_pat, k, g[9], g[8], g[7:0], busy, e[9], e[8], e[7:0]);
                end
                @(negedge clk);
                n_checks++;
                if (frame_done !== 1'(k == FRAME - 1)) begin
                    n_fail++;
                    $display("FAIL rand_done f=%0d k=%0d got %b expected %b", f, k, frame_done, k == FRAME - 1);
                end
                @(negedge clk);
            end
            fc_model++;
        end
    endtask

    task automatic test_reset_midline();
        bit found;
        pattern_sel = 2'd0;
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dvp_href === 1'b1 && dvp_db !== 8'h00) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rstmid_href got no href expected href within 200 pclk"); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dvp_pclk, dvp_vsync, dvp_href, dvp_db, busy, frame_done} !== 13'b0) begin
            n_fail++;
            $display("FAIL rstmid got pclk=%b vs=%b hr=%b db=%h busy=%b done=%b expected all 0",
                     dvp_pclk, dvp_vsync, dvp_href, dvp_db, busy, frame_done);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fc_model = 0;
    endtask

    initial begin
        test_reset();
        test_bars();
        test_back_to_back();
        test_enable_drop();
        test_pattern_change();
        test_random();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
